// File: rtl/note_player_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | note_player_pkg : FSM encoding, tempo table and period helper         |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package note_player_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_WAIT_DATA = 3'd2,
      ST_LATCH     = 3'd3,
      ST_HOLD      = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

   // Clock cycles per beat at 50 MHz, shared with the recorder's divider.
   localparam int unsigned TEMPO [8] = '{
      32'd75000000, 32'd50000000, 32'd37500000, 32'd30000000,
      32'd25000000, 32'd21428571, 32'd16666667, 32'd13636364
   };

   localparam int unsigned MIN_PERIOD = 3;

   function automatic logic [31:0] clamp_period(input logic [2:0] spd, input int unsigned div);
      int unsigned p;
      p = TEMPO[spd] / ((div == 0) ? 1 : div);
      if (p < MIN_PERIOD)
         p = MIN_PERIOD;
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/note_player_beat_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | note_player_beat_timer : loadable beat down-counter with zero flag    |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module note_player_beat_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!resetn)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_load_val;
      else if (i_dec && (r_cnt != '0))
         r_cnt <= r_cnt - 1'b1;
   end

   // Flags the decrement that lands on zero, so the owner can leave on that cycle.
   assign o_zero = (r_cnt[CNT_W-1:1] == '0);

endmodule
`default_nettype wire

// File: rtl/note_player.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | note_player : plays recorded note words back from RAM at a tempo      |
// | Option macro NOTE_PLAYER_LOOP_EN: repeat the recording until stop.   |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module note_player
   import note_player_pkg::*;
#(
   parameter int          NOTE_W     = 10,
   parameter int          ADDR_W     = 6,
   parameter int unsigned PERIOD_DIV = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              stop,
   input  logic [2:0]        speed,
   input  logic [ADDR_W:0]   rec_length,
   input  logic [NOTE_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   output logic [NOTE_W-1:0] note_out,
   output logic              note_valid,
   output logic              playing,
   output logic              done
);

   localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [31:0] c_PERIOD [8] = '{
      clamp_period(3'd0, PERIOD_DIV), clamp_period(3'd1, PERIOD_DIV),
      clamp_period(3'd2, PERIOD_DIV), clamp_period(3'd3, PERIOD_DIV),
      clamp_period(3'd4, PERIOD_DIV), clamp_period(3'd5, PERIOD_DIV),
      clamp_period(3'd6, PERIOD_DIV), clamp_period(3'd7, PERIOD_DIV)
   };

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [NOTE_W-1:0]   r_note;
   logic [ADDR_W:0]     w_len;
   logic [ADDR_W:0]     w_len_m1;
   logic                w_at_end;
   logic [31:0]         w_load_val;
   logic                w_beat_zero;
   logic                w_rd_en;
   logic                w_valid;
   logic                w_done;
   logic                w_load;
   logic                w_dec;
   logic                w_addr_clr;
   logic                w_addr_inc;
   logic                w_note_load;
   logic                w_note_clr;

   assign w_len      = (rec_length > c_DEPTH) ? c_DEPTH : rec_length;
   assign w_len_m1   = w_len - {{ADDR_W{1'b0}}, 1'b1};
   assign w_at_end   = ({1'b0, r_addr} == w_len_m1);
   assign w_load_val = c_PERIOD[speed] - 32'd3;

   note_player_beat_timer #(
      .CNT_W (32)
   ) u_beat_timer (
      .clk        (clk),
      .resetn     (resetn),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_zero     (w_beat_zero)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_note  <= '0;
      end else begin
         r_state <= w_next;
         if (w_addr_clr)
            r_addr <= '0;
         else if (w_addr_inc)
            r_addr <= r_addr + 1'b1;
         if (w_note_clr)
            r_note <= '0;
         else if (w_note_load)
            r_note <= mem_rdata;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_rd_en     = 1'b0;
      w_valid     = 1'b0;
      w_done      = 1'b0;
      w_load      = 1'b0;
      w_dec       = 1'b0;
      w_addr_clr  = 1'b0;
      w_addr_inc  = 1'b0;
      w_note_load = 1'b0;
      w_note_clr  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !stop) begin
               w_addr_clr = 1'b1;
               w_next     = (w_len == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            w_rd_en = 1'b1;
            w_next  = ST_WAIT_DATA;
         end
         // Capture read data here so note_out and note_valid appear together in LATCH.
         ST_WAIT_DATA: begin
            w_note_load = 1'b1;
            w_next      = ST_LATCH;
         end
         ST_LATCH: begin
            w_valid = 1'b1;
            w_load  = 1'b1;
            w_next  = ST_HOLD;
         end
         ST_HOLD: begin
            w_dec = 1'b1;
            if (w_beat_zero) begin
               if (w_at_end) begin
`ifdef NOTE_PLAYER_LOOP_EN
                  w_addr_clr = 1'b1;
                  w_next     = ST_FETCH;
`else
                  w_note_clr = 1'b1;
                  w_next     = ST_DONE;
`endif
               end else begin
                  w_addr_inc = 1'b1;
                  w_next     = ST_FETCH;
               end
            end
         end
         ST_DONE: begin
            w_done     = 1'b1;
            w_note_clr = 1'b1;
            w_next     = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
      // Abort overrides everything, including a read still in flight.
      if (stop && (r_state != ST_IDLE)) begin
         w_next      = ST_IDLE;
         w_addr_clr  = 1'b1;
         w_addr_inc  = 1'b0;
         w_note_load = 1'b0;
         w_note_clr  = 1'b1;
      end
   end

   assign mem_addr   = r_addr;
   assign mem_rd_en  = w_rd_en;
   assign note_out   = r_note;
   assign note_valid = w_valid;
   assign done       = w_done;
   assign playing    = (r_state != ST_IDLE) && (r_state != ST_DONE);

endmodule
`default_nettype wire
